// File: rtl/ksa_pkg.sv
// Shared types and constants for the RC4 key-scheduling engine.
package ksa_pkg;

  localparam int unsigned BYTE_W              = 8;
  localparam int unsigned KSA_CYCLES_PER_ITER = 6;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    RD_I,
    LD_I,
    RD_J,
    LD_J,
    WR_I,
    WR_J,
    DONE
  } ksa_state_e;

endpackage

// File: rtl/ksa_key_byte_sel.sv
// Selects key byte kidx from the latched key vector; byte 0 is the most significant byte.
module ksa_key_byte_sel
  import ksa_pkg::*;
#(
  parameter int unsigned KEY_BYTES = 3,
  parameter int unsigned KW        = 2
) (
  input  logic [BYTE_W*KEY_BYTES-1:0] key,
  input  logic [KW-1:0]               kidx,
  output logic [BYTE_W-1:0]           key_byte
);

  always_comb begin
    key_byte = '0;
    for (int unsigned k = 0; k < KEY_BYTES; k++) begin
      if (kidx == KW'(k)) key_byte = key[BYTE_W*(KEY_BYTES-1-k) +: BYTE_W];
    end
  end

endmodule

// File: rtl/ksa_engine.sv
// RC4 key-scheduling engine: initialises S[i]=i, then optionally runs the KSA swap loop
// against a single-port S memory with one-cycle read latency.
module ksa_engine
  import ksa_pkg::*;
#(
  parameter int unsigned N         = 256,
  parameter int unsigned KEY_BYTES = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        init_only,
  input  logic [BYTE_W*KEY_BYTES-1:0] key,
  output logic [$clog2(N)-1:0]        s_address,
  output logic [BYTE_W-1:0]           s_data,
  output logic                        s_wren,
  input  logic [BYTE_W-1:0]           s_q,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned AW = $clog2(N);
  localparam int unsigned KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [AW-1:0] I_LAST = AW'(N - 1);
  localparam logic [KW-1:0] K_LAST = KW'(KEY_BYTES - 1);

  ksa_state_e                  state;
  logic [AW-1:0]               i;
  logic [AW-1:0]               j;
  logic [AW-1:0]               j_next;
  logic [KW-1:0]               kidx;
  logic [BYTE_W-1:0]           si;
  logic [BYTE_W-1:0]           sj;
  logic [BYTE_W-1:0]           key_byte;
  logic [BYTE_W*KEY_BYTES-1:0] key_q;
  logic                        init_only_q;

  ksa_key_byte_sel #(
    .KEY_BYTES(KEY_BYTES),
    .KW       (KW)
  ) u_key_byte_sel (
    .key     (key_q),
    .kidx    (kidx),
    .key_byte(key_byte)
  );

  // Sum in 8 bits, then keep the low AW bits: equivalent to mod N for power-of-2 N.
  assign j_next = AW'(BYTE_W'(j) + s_q + key_byte);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      i           <= '0;
      j           <= '0;
      kidx        <= '0;
      si          <= '0;
      sj          <= '0;
      key_q       <= '0;
      init_only_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            key_q       <= key;
            init_only_q <= init_only;
            i           <= '0;
            j           <= '0;
            kidx        <= '0;
            state       <= INIT;
          end
        end
        INIT: begin
          if (i == I_LAST) begin
            i     <= '0;
            state <= init_only_q ? DONE : RD_I;
          end else begin
            i <= i + 1'b1;
          end
        end
        RD_I: state <= LD_I;
        LD_I: begin
          si    <= s_q;
          j     <= j_next;
          state <= RD_J;
        end
        RD_J: state <= LD_J;
        LD_J: begin
          sj    <= s_q;
          state <= WR_I;
        end
        WR_I: state <= WR_J;
        WR_J: begin
          if (i == I_LAST) begin
            state <= DONE;
          end else begin
            i     <= i + 1'b1;
            kidx  <= (kidx == K_LAST) ? '0 : kidx + 1'b1;
            state <= RD_I;
          end
        end
        DONE: if (!start) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_address = '0;
    s_data    = '0;
    s_wren    = 1'b0;
    case (state)
      INIT: begin
        s_address = i;
        s_data    = BYTE_W'(i);
        s_wren    = 1'b1;
      end
      RD_I: s_address = i;
      RD_J: s_address = j;
      WR_I: begin
        s_address = i;
        s_data    = sj;
        s_wren    = 1'b1;
      end
      WR_J: begin
        s_address = j;
        s_data    = si;
        s_wren    = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

endmodule
